jt51_kon_sched: RTL and testbench

- Key-on scheduler for the 32-slot time-multiplexed operator pipeline.
- Owns the slot counter and queues CPU key-on/off commands in a small FIFO.
- Applies each command atomically across one full 32-slot frame.
- Per slot, emits the key state and a one-cycle pg_rst pulse on off->on transitions; this drives the phase generator's phase-reset input and the envelope key-on input.

---
 rtl/jt51_kon_sched.sv | 140 ++++++++++++++
 tb/tb_jt51_kon_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_kon_sched.sv
// Key-on scheduler: owns the 32-slot counter, queues CPU key commands and
// applies one command per full frame, emitting per-slot key state and phase reset.
module jt51_kon_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_DLY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       kon_we,
  input  logic [2:0] kon_ch,
  input  logic [3:0] kon_op,
  input  logic       kon_clr,
  output logic       full,
  output logic       ovf,
  output logic       zero,
  output logic [4:0] slot_o,
  output logic       kon_o,
  output logic       pg_rst_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [4:0]     r_cnt;
  logic [31:0]    r_ks;
  logic [6:0]     r_fifo [FIFO_DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic [2:0]     r_act_ch;
  logic [3:0]     r_act_op;
  logic           r_ovf;
  logic           r_clr_pend;
  logic           r_clr_frame;
  logic [6:0]     r_dly [0:OUT_DLY];

  logic           w_last;
  logic           w_empty;
  logic           w_full;
  logic           w_clr_go;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic           w_new;
  logic           w_pg;
  logic [AW-1:0]  w_wr_ptr;

  assign w_last   = (r_cnt == 5'd31);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_clr_go = cen && w_last && (r_clr_pend || kon_clr);
  assign w_pop    = cen && w_last && !w_clr_go && !w_empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign w_push   = cen && kon_we && (!w_full || w_pop) && !w_clr_go;
  assign w_drop   = kon_we && w_full && !w_pop && !w_clr_go;
  assign w_wr_ptr = r_rd_ptr + r_count[AW-1:0];

  assign full  = w_full;
  assign ovf   = r_ovf;
  assign zero  = (r_cnt == 5'd0);
  assign {slot_o, kon_o, pg_rst_o} = r_dly[OUT_DLY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_go)              w_state_nxt = IDLE;
    else if (w_pop)            w_state_nxt = APPLY;
    else if (cen && w_last)    w_state_nxt = IDLE;
  end

  always_comb begin
    w_new = r_ks[r_cnt];
    if (r_clr_frame)
      w_new = 1'b0;
    else if (r_state == APPLY && r_cnt[2:0] == r_act_ch)
      w_new = r_act_op[r_cnt[4:3]];
    w_pg = w_new & ~r_ks[r_cnt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_act_ch <= '0;
      r_act_op <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else if (cen) begin
      if (w_clr_go) begin
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_fifo[w_wr_ptr] <= {kon_ch, kon_op};
        if (w_pop) begin
          {r_act_ch, r_act_op} <= r_fifo[r_rd_ptr];
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_ks        <= '0;
      r_ovf       <= 1'b0;
      r_clr_pend  <= 1'b0;
      r_clr_frame <= 1'b0;
    end else if (cen) begin
      r_cnt        <= r_cnt + 5'd1;
      r_ks[r_cnt]  <= w_new;
      r_ovf        <= w_drop;
      if (w_clr_go)     r_clr_pend <= 1'b0;
      else if (kon_clr) r_clr_pend <= 1'b1;
      if (w_last)       r_clr_frame <= w_clr_go;
    end
  end

  // Output stages keep slot, key state and phase reset travelling together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= OUT_DLY; i++) r_dly[i] <= '0;
    end else if (cen) begin
      r_dly[0] <= {r_cnt, w_new, w_pg};
      for (int i = 1; i <= OUT_DLY; i++) r_dly[i] <= r_dly[i-1];
    end
  end

endmodule

// File: tb/tb_jt51_kon_sched.sv
// Directed bench for jt51_kon_sched: frames are captured per slot and compared
// against hand-computed 32-bit key and phase-reset masks.
module tb_jt51_kon_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       kon_we;
  logic [2:0] kon_ch;
  logic [3:0] kon_op;
  logic       kon_clr;
  logic       full;
  logic       ovf;
  logic       zero;
  logic [4:0] slot_o;
  logic       kon_o;
  logic       pg_rst_o;

  int errors = 0;
  int checks = 0;
  int tbCnt  = 0;

  always #5 clk = ~clk;

  jt51_kon_sched #(.FIFO_DEPTH(4), .OUT_DLY(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .kon_we   (kon_we),
    .kon_ch   (kon_ch),
    .kon_op   (kon_op),
    .kon_clr  (kon_clr),
    .full     (full),
    .ovf      (ovf),
    .zero     (zero),
    .slot_o   (slot_o),
    .kon_o    (kon_o),
    .pg_rst_o (pg_rst_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock; the bench's own slot counter follows the DUT when cen was high.
  task automatic tick();
    logic c;
    c = cen;
    @(negedge clk);
    if (c && rst_n) tbCnt = (tbCnt + 1) % 32;
  endtask

  task automatic waitCnt(input int target);
    for (int i = 0; i < 40 && tbCnt != target; i++) tick();
  endtask

  task automatic applyStimulus(input logic [2:0] ch, input logic [3:0] op);
    kon_we = 1'b1;
    kon_ch = ch;
    kon_op = op;
    tick();
    kon_we = 1'b0;
  endtask

  // slot_o lags the counter by three, so a frame is read from cnt=3 onwards.
  task automatic captureFrame(output logic [31:0] konMask, output logic [31:0] pgMask);
    int bad;
    bad = 0;
    konMask = '0;
    pgMask  = '0;
    waitCnt(3);
    for (int i = 0; i < 32; i++) begin
      if (slot_o !== 5'(i)) bad++;
      konMask[i] = kon_o;
      pgMask[i]  = pg_rst_o;
      tick();
    end
    checkOutput("slotAlign", bad, 0);
  endtask

  initial begin
    logic [31:0] km;
    logic [31:0] pm;
    int bad;
    int zeros;

    rst_n = 1'b0; cen = 1'b1; kon_we = 1'b0; kon_clr = 1'b0;
    kon_ch = '0; kon_op = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstKon",  kon_o, 0);
    checkOutput("rstPg",   pg_rst_o, 0);
    checkOutput("rstSlot", slot_o, 0);
    checkOutput("rstZero", zero, 1);
    checkOutput("rstFull", full, 0);
    checkOutput("rstOvf",  ovf, 0);
    rst_n = 1'b1;
    tbCnt = 0;

    // Two idle frames straight after reset
    bad = 0; zeros = 0;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (kon_o || pg_rst_o) bad++;
      if (zero) zeros++;
      if (zero !== (tbCnt == 0)) bad++;
      if (k >= 3 && slot_o !== 5'((tbCnt + 29) % 32)) bad++;
    end
    checkOutput("idleFrames", bad, 0);
    checkOutput("zeroCount", zeros, 2);

    // Key-on all four operators of channel 2
    waitCnt(10);
    applyStimulus(3'd2, 4'b1111);
    captureFrame(km, pm);
    checkOutput("konCh2On", km, 32'h04040404);
    checkOutput("pgCh2On",  pm, 32'h04040404);
    captureFrame(km, pm);
    checkOutput("konCh2Hold", km, 32'h04040404);
    checkOutput("pgCh2Hold",  pm, 32'h00000000);

    // Partial key-off: operators 1 and 3 go off
    waitCnt(10);
    applyStimulus(3'd2, 4'b0101);
    captureFrame(km, pm);
    checkOutput("konPartialOff", km, 32'h00040004);
    checkOutput("pgPartialOff",  pm, 32'h00000000);

    // Fill the FIFO, overflow on the fifth write
    waitCnt(5);
    applyStimulus(3'd0, 4'b0001);
    applyStimulus(3'd0, 4'b0010);
    applyStimulus(3'd7, 4'b1000);
    checkOutput("fullAfter3", full, 0);
    applyStimulus(3'd2, 4'b0000);
    checkOutput("fullAfter4", full, 1);
    checkOutput("ovfAfter4",  ovf, 0);
    applyStimulus(3'd5, 4'b1111);
    checkOutput("ovfOn5th",   ovf, 1);
    checkOutput("fullAfter5", full, 1);
    cen = 1'b0;
    repeat (3) tick();
    checkOutput("ovfHeldCen0",  ovf, 1);
    checkOutput("slotHeldCen0", slot_o, 7);
    cen = 1'b1;
    tick();
    checkOutput("ovfCleared", ovf, 0);
    checkOutput("fullHold",   full, 1);

    // Write while full exactly on the pop cycle
    waitCnt(31);
    applyStimulus(3'd5, 4'b0001);
    checkOutput("ovfPushAtPop",  ovf, 0);
    checkOutput("fullPushAtPop", full, 1);

    captureFrame(km, pm);
    checkOutput("konQ1", km, 32'h00040005);
    checkOutput("pgQ1",  pm, 32'h00000001);
    captureFrame(km, pm);
    checkOutput("konQ2", km, 32'h00040104);
    checkOutput("pgQ2",  pm, 32'h00000100);
    captureFrame(km, pm);
    checkOutput("konQ3", km, 32'h80040104);
    checkOutput("pgQ3",  pm, 32'h80000000);
    captureFrame(km, pm);
    checkOutput("konQ4", km, 32'h80000100);
    checkOutput("pgQ4",  pm, 32'h00000000);
    captureFrame(km, pm);
    checkOutput("konQ5", km, 32'h80000120);
    checkOutput("pgQ5",  pm, 32'h00000020);
    captureFrame(km, pm);
    checkOutput("konIdleAfterQ", km, 32'h80000120);
    checkOutput("pgIdleAfterQ",  pm, 32'h00000000);

    // Clear with three commands queued plus a write on the flush cycle
    waitCnt(5);
    applyStimulus(3'd1, 4'b1111);
    applyStimulus(3'd3, 4'b1111);
    applyStimulus(3'd4, 4'b1111);
    kon_clr = 1'b1;
    tick();
    kon_clr = 1'b0;
    waitCnt(31);
    applyStimulus(3'd0, 4'b1111);
    checkOutput("ovfAtFlush",  ovf, 0);
    checkOutput("fullAtFlush", full, 0);
    captureFrame(km, pm);
    checkOutput("konClearFrame", km, 32'h00000000);
    checkOutput("pgClearFrame",  pm, 32'h00000000);
    captureFrame(km, pm);
    checkOutput("konAfterFlush", km, 32'h00000000);
    checkOutput("pgAfterFlush",  pm, 32'h00000000);

    // Asynchronous reset in the middle of an active frame
    waitCnt(10);
    applyStimulus(3'd6, 4'b1111);
    waitCnt(0);
    waitCnt(17);
    checkOutput("preRstSlot", slot_o, 14);
    checkOutput("preRstKon",  kon_o, 1);
    checkOutput("preRstPg",   pg_rst_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstKon",  kon_o, 0);
    checkOutput("midRstPg",   pg_rst_o, 0);
    checkOutput("midRstSlot", slot_o, 0);
    checkOutput("midRstZero", zero, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tbCnt = 0;
    captureFrame(km, pm);
    checkOutput("konAfterRst", km, 32'h00000000);
    checkOutput("pgAfterRst",  pm, 32'h00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
